wrr_lock_arbiter: RTL
=====================

WRR_LOCK_ARBITER -- requirements
Module: wrr_lock_arbiter

Interface
REQ-001 SHALL have parameter CLIENTS, default 8, number of requestors (>=2).
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-client weight.
REQ-003 SHALL derive localparam CLIENTS_W = $clog2(CLIENTS).
REQ-004 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port request  input  CLIENTS  per-client active-high request, held until granted.
REQ-007 SHALL have port weight  input  CLIENTS*WEIGHT_W  weight[c] = bits [c*WEIGHT_W +: WEIGHT_W], extra back-to-back grants per turn.
REQ-008 SHALL have port lock  input  1  hold the current grant next cycle (multi-cycle transfer).
REQ-009 SHALL have port stall  input  1  suppresses arbitration for the cycle.
REQ-010 SHALL have port grant  output  CLIENTS  one-hot grant, combinational, same cycle as request.
REQ-011 SHALL have port grant_id  output  CLIENTS_W  index of the granted client, 0 when grant_valid=0.
REQ-012 SHALL have port grant_valid  output  1  equals |grant.

Function
REQ-013 SHALL keep state owner (CLIENTS_W), credit (WEIGHT_W) and locked (1).
REQ-014 SHALL drive grant=0, grant_valid=0, grant_id=0 when stall=1 or request=0, and SHALL hold all state in those cycles.
REQ-015 SHALL, if locked=1 and request[owner]=1, grant owner and leave credit unchanged.
REQ-016 SHALL, if locked=0, request[owner]=1 and credit!=0, grant owner (burst continue) and set credit<=credit-1.
REQ-017 SHALL otherwise grant the first requesting client searching owner+1, owner+2, ... with wrap modulo CLIENTS, owner itself checked last.
REQ-018 SHALL, on a REQ-017 selection sel, set owner<=sel and credit<=weight[sel]; weight is sampled only here.
REQ-019 SHALL treat weight[c]=0 as one grant per turn, i.e. plain round-robin.
REQ-020 SHALL give a client at most weight[c]+1 unlocked grants per turn.
REQ-021 SHALL set locked<=lock & grant_valid on every non-stalled cycle; lock with no grant SHALL have no effect.
REQ-022 SHALL drop lock hold if the owner deasserts request while locked; selection then follows REQ-017 in that same cycle.
REQ-023 SHALL keep grant strictly one-hot or zero, and grant[i]=1 only when request[i]=1.
REQ-024 SHALL never starve a continuously requesting client while lock is not held indefinitely: wait <= sum over others of (weight+1) grants.

Reset
REQ-025 SHALL, on reset assertion, immediately and asynchronously set owner=CLIENTS-1, credit=0 and locked=0, so client 0 has highest priority.
REQ-026 SHALL hold grant=0 while reset=1 regardless of request.
REQ-027 SHALL abandon any burst or lock in progress on reset and restart arbitration from client 0 on the first cycle after release.

Verification (CLIENTS=4, WEIGHT_W=2)
REQ-028 SHALL cover basic round-robin: weights all 0, request=4'b1111 -> grant_id 0,1,2,3,0 on consecutive cycles.
REQ-029 SHALL cover a weighted burst: weight[0]=2, others 0, request=4'b1111 -> grant_id 0,0,0,1,2,3,0,0,0.
REQ-030 SHALL cover stall mid-burst: as REQ-029 with stall=1 on cycle 2 -> grant_id 0,0,(none),0,1; credit preserved across the stall.
REQ-031 SHALL cover lock: request=4'b0011, weights 0, lock=1 for cycles 0-2 -> grant_id 0,0,0,0 then 1; lock with request[0] dropped at cycle 2 -> grant_id 1 on cycle 2.
REQ-032 SHALL cover async reset: reset pulsed between edges during the burst of client 2 -> grant=0 immediately; after release with request=4'b1111, first grant_id=0.
REQ-033 SHALL cover a single requester: request=4'b1000 with weights 0 -> grant_id=3 every cycle; wrap search from owner=3 back to 3.

Source files
------------

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with per-client burst credit and a lock input
// that keeps the current grant across multi-cycle transfers.
module wrr_lock_arbiter #(
  parameter  int CLIENTS   = 8,
  parameter  int WEIGHT_W  = 4,
  localparam int CLIENTS_W = $clog2(CLIENTS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CLIENTS-1:0]           request,
  input  logic [CLIENTS*WEIGHT_W-1:0]  weight,
  input  logic                         lock,
  input  logic                         stall,
  output logic [CLIENTS-1:0]           grant,
  output logic [CLIENTS_W-1:0]         grant_id,
  output logic                         grant_valid
);

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_HOLD,
    DEC_BURST,
    DEC_SELECT
  } decision_e;

  logic [CLIENTS_W-1:0] owner_q, owner_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic                 locked_q, locked_d;

  logic [CLIENTS_W-1:0] searchCand;
  logic [CLIENTS_W-1:0] searchSel;
  logic                 searchFound;
  decision_e            decision;
  logic [CLIENTS_W-1:0] winner;

  function automatic logic [CLIENTS_W-1:0] wrapAdd(input logic [CLIENTS_W-1:0] base,
                                                    input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= CLIENTS) sum = sum - CLIENTS;
    return CLIENTS_W'(sum);
  endfunction

  // Rotating priority search starting just after the owner; the owner is visited last.
  always_comb begin
    searchFound = 1'b0;
    searchSel   = '0;
    searchCand  = '0;
    for (int k = 1; k <= CLIENTS; k++) begin
      searchCand = wrapAdd(owner_q, k);
      if (!searchFound && request[searchCand]) begin
        searchFound = 1'b1;
        searchSel   = searchCand;
      end
    end
  end

  always_comb begin
    decision = DEC_IDLE;
    winner   = '0;
    if (!reset && !stall && (|request)) begin
      if (locked_q && request[owner_q]) begin
        decision = DEC_HOLD;
        winner   = owner_q;
      end else if (!locked_q && request[owner_q] && (credit_q != '0)) begin
        decision = DEC_BURST;
        winner   = owner_q;
      end else if (searchFound) begin
        decision = DEC_SELECT;
        winner   = searchSel;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (decision != DEC_IDLE) grant[winner] = 1'b1;
    grant_id    = winner;
    grant_valid = |grant;
  end

  // Idle cycles (stall, no request) leave owner, credit and lock untouched.
  always_comb begin
    owner_d  = owner_q;
    credit_d = credit_q;
    locked_d = locked_q;
    if (decision != DEC_IDLE) locked_d = lock;
    case (decision)
      DEC_BURST: credit_d = credit_q - WEIGHT_W'(1);
      DEC_SELECT: begin
        owner_d  = winner;
        credit_d = weight[winner*WEIGHT_W +: WEIGHT_W];
      end
      default: ;
    endcase
  end

  // Owner resets to the last client so client 0 wins the first search.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q  <= CLIENTS_W'(CLIENTS - 1);
      credit_q <= '0;
      locked_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
      locked_q <= locked_d;
    end
  end

endmodule
